// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, counter widths and lock FSM encoding.
package vga_timing_pkg;

  localparam int unsigned H_DISPLAY_DEF    = 640;
  localparam int unsigned H_TOTAL_DEF      = 800;
  localparam int unsigned H_SYNC_START_DEF = 656;
  localparam int unsigned V_DISPLAY_DEF    = 480;
  localparam int unsigned V_TOTAL_DEF      = 525;
  localparam int unsigned V_SYNC_START_DEF = 490;
  localparam int unsigned LOCK_FRAMES_DEF  = 2;

  localparam int unsigned HPOS_W = 10;
  localparam int unsigned VPOS_W = 10;
  localparam int unsigned HLEN_W = 11;
  localparam int unsigned VCNT_W = 10;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lock_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Sample register plus rising-edge detect for one incoming sync line.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_in,
  output logic rise_c
);

  logic sync_q;

  // One-cycle history of the sync input
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= 1'b0;
    else        sync_q <= sync_in;
  end

  assign rise_c = sync_in & ~sync_q;

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: recovers pixel/line position from hsync/vsync and
// declares lock after LOCK_FRAMES consecutive well-formed frames.
// Optional build macro VGA_SYNC_RX_MEASURE_EN adds h_period/v_lines registers.
module vga_sync_receiver
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY    = H_DISPLAY_DEF,
  parameter int unsigned H_TOTAL      = H_TOTAL_DEF,
  parameter int unsigned H_SYNC_START = H_SYNC_START_DEF,
  parameter int unsigned V_DISPLAY    = V_DISPLAY_DEF,
  parameter int unsigned V_TOTAL      = V_TOTAL_DEF,
  parameter int unsigned V_SYNC_START = V_SYNC_START_DEF,
  parameter int unsigned LOCK_FRAMES  = LOCK_FRAMES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic [HPOS_W-1:0] hpos,
  output logic [VPOS_W-1:0] vpos,
  output logic              display_on,
  output logic              locked,
  output logic              frame_start,
  output logic              err,
  output logic [HLEN_W-1:0] h_period,
  output logic [VCNT_W-1:0] v_lines
);

  localparam int unsigned LEN_W    = HLEN_W + 1;
  localparam int unsigned WD_LIMIT = 2 * H_TOTAL;
  localparam int unsigned WD_W     = $clog2(WD_LIMIT + 1);
  localparam int unsigned GF_W     = $clog2(LOCK_FRAMES + 1);

  logic              h_rise_c, v_rise_c, h_wrap_c;
  logic [HPOS_W-1:0] hpos_q, hpos_d;
  logic [VPOS_W-1:0] vpos_q, vpos_d;
  logic [HLEN_W-1:0] line_cnt_q, line_cnt_d;
  logic [LEN_W-1:0]  line_len_c;
  logic              line_good_c;
  logic [VCNT_W-1:0] fline_cnt_q, fline_cnt_d, fline_eff_c;
  logic              fgood_q, fgood_d, frame_good_c;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic              wd_timeout_c;
  lock_state_e       state_q, state_d;
  logic [GF_W-1:0]   gfc_q, gfc_d;
  int unsigned       gfc_inc_c;
  logic              err_d;
  logic              locked_q, err_q, frame_start_q;

  sync_edge_detect u_hsync_edge (.clk(clk), .rst_n(rst_n), .sync_in(hsync_in), .rise_c(h_rise_c));
  sync_edge_detect u_vsync_edge (.clk(clk), .rst_n(rst_n), .sync_in(vsync_in), .rise_c(v_rise_c));

  assign h_wrap_c     = !h_rise_c && (hpos_q == HPOS_W'(H_TOTAL - 1));
  assign line_len_c   = LEN_W'(line_cnt_q) + LEN_W'(1);
  assign line_good_c  = (line_len_c == LEN_W'(H_TOTAL));
  // A coincident hsync edge closes its line into the frame being closed
  assign fline_eff_c  = (h_rise_c && fline_cnt_q != '1) ? fline_cnt_q + VCNT_W'(1) : fline_cnt_q;
  assign frame_good_c = fgood_q && (!h_rise_c || line_good_c) &&
                        (fline_eff_c == VCNT_W'(V_TOTAL));
  assign wd_timeout_c = !h_rise_c && (wd_cnt_q >= WD_W'(WD_LIMIT - 1));
  assign gfc_inc_c    = 32'(gfc_q) + 32'd1;

  // Position, line/frame measurement and watchdog next-state
  always_comb begin
    hpos_d = hpos_q + HPOS_W'(1);
    if (h_rise_c)      hpos_d = HPOS_W'(H_SYNC_START + 1);
    else if (h_wrap_c) hpos_d = '0;

    vpos_d = vpos_q;
    if (v_rise_c)      vpos_d = VPOS_W'(V_SYNC_START);
    else if (h_wrap_c) vpos_d = (vpos_q == VPOS_W'(V_TOTAL - 1)) ? '0 : vpos_q + VPOS_W'(1);

    line_cnt_d = (line_cnt_q == '1) ? line_cnt_q : line_cnt_q + HLEN_W'(1);
    if (h_rise_c) line_cnt_d = '0;

    fline_cnt_d = fline_cnt_q;
    fgood_d     = fgood_q;
    if (v_rise_c) begin
      fline_cnt_d = '0;
      fgood_d     = 1'b1;
    end else if (h_rise_c) begin
      fline_cnt_d = fline_eff_c;
      fgood_d     = fgood_q && line_good_c;
    end

    wd_cnt_d = (wd_cnt_q == WD_W'(WD_LIMIT)) ? wd_cnt_q : wd_cnt_q + WD_W'(1);
    if (h_rise_c) wd_cnt_d = '0;
  end

  // Lock FSM next-state and err decode
  always_comb begin
    state_d = state_q;
    gfc_d   = gfc_q;
    err_d   = 1'b0;
    case (state_q)
      SEARCH: begin
        if (v_rise_c) begin
          state_d = VERIFY;
          gfc_d   = '0;
        end
      end
      VERIFY: begin
        if (wd_timeout_c) begin
          state_d = SEARCH;
        end else if (v_rise_c) begin
          if (!frame_good_c) begin
            gfc_d = '0;
          end else begin
            gfc_d = GF_W'(gfc_inc_c);
            if (gfc_inc_c >= LOCK_FRAMES) state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if ((h_rise_c && !line_good_c) || (v_rise_c && !frame_good_c) || wd_timeout_c)
          state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase
    err_d = (state_q == LOCKED) && (state_d != LOCKED);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hpos_q        <= '0;
      vpos_q        <= '0;
      line_cnt_q    <= '0;
      fline_cnt_q   <= '0;
      fgood_q       <= 1'b0;
      wd_cnt_q      <= '0;
      state_q       <= SEARCH;
      gfc_q         <= '0;
      locked_q      <= 1'b0;
      err_q         <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      line_cnt_q    <= line_cnt_d;
      fline_cnt_q   <= fline_cnt_d;
      fgood_q       <= fgood_d;
      wd_cnt_q      <= wd_cnt_d;
      state_q       <= state_d;
      gfc_q         <= gfc_d;
      locked_q      <= (state_d == LOCKED);
      err_q         <= err_d;
      frame_start_q <= (state_d == LOCKED) && (hpos_d == '0) && (vpos_d == '0);
    end
  end

`ifdef VGA_SYNC_RX_MEASURE_EN
  logic [HLEN_W-1:0] h_period_q;
  logic [VCNT_W-1:0] v_lines_q;
  logic [HLEN_W-1:0] line_len_sat_c;

  assign line_len_sat_c = (line_cnt_q == '1) ? line_cnt_q : line_cnt_q + HLEN_W'(1);

  // Last measured line length and lines per frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_period_q <= '0;
      v_lines_q  <= '0;
    end else begin
      if (h_rise_c) h_period_q <= line_len_sat_c;
      if (v_rise_c) v_lines_q  <= fline_eff_c;
    end
  end

  assign h_period = h_period_q;
  assign v_lines  = v_lines_q;
`else
  assign h_period = '0;
  assign v_lines  = '0;
`endif

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign locked      = locked_q;
  assign err         = err_q;
  assign frame_start = frame_start_q;
  assign display_on  = locked_q && (hpos_q < HPOS_W'(H_DISPLAY)) && (vpos_q < VPOS_W'(V_DISPLAY));

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Scoreboard bench for vga_sync_receiver using a reduced raster so whole
// frames stay short; a reference sync generator drives the stream.
module tb_vga_sync_receiver;

  localparam int HT  = 40;
  localparam int HD  = 32;
  localparam int HSS = 34;
  localparam int HSW = 4;
  localparam int VT  = 20;
  localparam int VD  = 16;
  localparam int VSS = 17;
  localparam int VSW = 2;

`ifdef VGA_SYNC_RX_MEASURE_EN
  localparam int MEAS_H = HT;
  localparam int MEAS_V = VT;
`else
  localparam int MEAS_H = 0;
  localparam int MEAS_V = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hsync_in, vsync_in;
  logic [9:0] hpos, vpos;
  logic       display_on, locked, frame_start, err;
  logic [10:0] h_period;
  logic [9:0]  v_lines;

  vga_sync_receiver #(
    .H_DISPLAY(HD), .H_TOTAL(HT), .H_SYNC_START(HSS),
    .V_DISPLAY(VD), .V_TOTAL(VT), .V_SYNC_START(VSS), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hpos(hpos), .vpos(vpos), .display_on(display_on), .locked(locked),
    .frame_start(frame_start), .err(err), .h_period(h_period), .v_lines(v_lines)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int due;
    int sig;
    int val;
    int scen;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   scen  = 0;

  // generator state
  int gh = 0, gv = 0;
  bit skip_pix = 0, skip_line = 0, track = 0;
  int sup_lo = -1, sup_hi = -1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      0: return 32'(hpos);
      1: return 32'(vpos);
      2: return 32'(locked);
      3: return 32'(err);
      4: return 32'(frame_start);
      5: return 32'(display_on);
      6: return 32'(h_period);
      default: return 32'(v_lines);
    endcase
  endfunction

  function automatic string sig_name(input int sig);
    case (sig)
      0: return "hpos";
      1: return "vpos";
      2: return "locked";
      3: return "err";
      4: return "frame_start";
      5: return "display_on";
      6: return "h_period";
      default: return "v_lines";
    endcase
  endfunction

  task automatic sb_push(input int due, input int sig, input int val);
    sb.push_back(exp_t'{due, sig, val, scen});
  endtask

  // Pop and compare every expectation due in the current cycle
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check_eq($sformatf("s%0d_%s@%0d", sb[i].scen, sig_name(sb[i].sig), cyc),
                 observe(sb[i].sig), 32'(sb[i].val));
        sb.delete(i);
      end else if (sb[i].due < cyc) begin
        check_eq($sformatf("s%0d_%s_late", sb[i].scen, sig_name(sb[i].sig)), 32'(sb[i].due), 32'(cyc));
        sb.delete(i);
      end
    end
  end

  task automatic drive_raw(input logic h, input logic v, output int k);
    @(posedge clk); #1;
    k = cyc;
    hsync_in = h;
    vsync_in = v;
  endtask

  // One generator clock: drive syncs for position (gh,gv), then advance
  task automatic step(output bit he, output bit ve, output int k);
    bit hs, vs, sup;
    @(posedge clk); #1;
    k   = cyc;
    sup = (k >= sup_lo) && (k <= sup_hi);
    hs  = (gh >= HSS) && (gh < HSS + HSW) && !sup;
    vs  = (gv >= VSS) && (gv < VSS + VSW);
    he  = (gh == HSS) && !sup;
    ve  = (gh == 0) && (gv == VSS);
    hsync_in = hs;
    vsync_in = vs;
    if (track) begin
      sb_push(k, 0, gh);
      sb_push(k, 1, gv);
      sb_push(k, 2, 1);
      sb_push(k, 3, 0);
      sb_push(k, 4, int'(gh == 0 && gv == 0));
      sb_push(k, 5, int'(gh < HD && gv < VD));
    end
    if (skip_pix && gh == 10) begin
      gh = 12;
      skip_pix = 0;
    end else if (gh == HT - 1) begin
      gh = 0;
      if (skip_line && gv == 5) begin
        gv = 7;
        skip_line = 0;
      end else begin
        gv = (gv == VT - 1) ? 0 : gv + 1;
      end
    end else begin
      gh++;
    end
  endtask

  task automatic run_vedges(input int n, output int k);
    bit he, ve;
    int c = 0;
    while (c < n) begin
      step(he, ve, k);
      if (ve) c++;
    end
  endtask

  task automatic run_until_h(input int line, output int k);
    bit he, ve;
    do step(he, ve, k); while (!(he && gv == line));
  endtask

  // From SEARCH: still unlocked after 2nd vsync edge, locked after the 3rd
  task automatic relock_check();
    int k;
    run_vedges(2, k);
    sb_push(k + 1, 2, 0);
    run_vedges(1, k);
    sb_push(k, 2, 0);
    sb_push(k + 1, 2, 1);
    sb_push(k + 1, 3, 0);
    sb_push(k + 1, 6, MEAS_H);
    sb_push(k + 1, 7, MEAS_V);
  endtask

  initial begin
    int k;
    bit he, ve;
    rst_n = 1'b0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;

    // reset state
    scen = 0;
    drive_raw(0, 0, k);
    drive_raw(0, 0, k);
    for (int s = 0; s < 8; s++) sb_push(k + 1, s, 0);
    drive_raw(0, 0, k);
    rst_n = 1'b1;

    // coincident hsync and vsync edges
    scen = 5;
    drive_raw(1, 1, k);
    sb_push(k + 1, 0, HSS + 1);
    sb_push(k + 1, 1, VSS);
    sb_push(k + 1, 2, 0);
    drive_raw(0, 0, k);
    rst_n = 1'b0;
    drive_raw(0, 0, k);
    drive_raw(0, 0, k);
    rst_n = 1'b1;
    gh = 0;
    gv = 0;

    // lock from reset, then one fully tracked frame
    scen = 1;
    relock_check();
    track = 1;
    repeat (HT * VT) step(he, ve, k);
    track = 0;

    // one short line while locked
    scen = 2;
    run_until_h(4, k);
    skip_pix = 1;
    run_until_h(5, k);
    sb_push(k, 3, 0);
    sb_push(k, 2, 1);
    sb_push(k + 1, 3, 1);
    sb_push(k + 1, 2, 0);
    sb_push(k + 2, 3, 0);
    relock_check();

    // hsync stuck low: watchdog
    scen = 3;
    run_until_h(2, k);
    sup_lo = k + 1;
    sup_hi = k + 2 * HT;
    sb_push(k + 2 * HT, 2, 1);
    sb_push(k + 2 * HT, 3, 0);
    sb_push(k + 2 * HT + 1, 2, 0);
    sb_push(k + 2 * HT + 1, 3, 1);
    sb_push(k + 2 * HT + 2, 3, 0);

    // short frame in VERIFY clears the good-frame count
    scen = 4;
    run_vedges(1, k);
    sb_push(k + 1, 2, 0);
    run_vedges(1, k);
    sb_push(k + 1, 2, 0);
    skip_line = 1;
    run_vedges(1, k);
    sb_push(k + 1, 2, 0);
    run_vedges(1, k);
    sb_push(k + 1, 2, 0);
    run_vedges(1, k);
    sb_push(k + 1, 2, 1);
    sb_push(k + 1, 7, MEAS_V);

    // reset pulse mid-frame while locked
    scen = 6;
    while (!(gv == 5 && gh == 20)) step(he, ve, k);
    step(he, ve, k);
    sb_push(k, 2, 1);
    rst_n = 1'b0;
    for (int s = 0; s < 8; s++) sb_push(k + 1, s, 0);
    step(he, ve, k);
    rst_n = 1'b1;
    relock_check();

    repeat (5) step(he, ve, k);
    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_sync_receiver.md
VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- H_DISPLAY, 640, visible pixels per line
- H_TOTAL, 800, clocks per line
- H_SYNC_START, 656, pixel index of the hsync leading edge
- V_DISPLAY, 480, visible lines
- V_TOTAL, 525, lines per frame
- V_SYNC_START, 490, line index of the vsync leading edge
- LOCK_FRAMES, 2, consecutive good frames required for lock
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, pixel clock; sole clock
- rst_n, in, 1, synchronous active-low reset
- hsync_in, in, 1, incoming horizontal sync, active high
- vsync_in, in, 1, incoming vertical sync, active high
- hpos, out, 10, recovered pixel column
- vpos, out, 10, recovered line
- display_on, out, 1, locked and within the visible area
- locked, out, 1, timing lock achieved
- frame_start, out, 1, one-cycle pulse at the frame origin
- err, out, 1, one-cycle pulse on loss of lock
- h_period, out, 11, last measured line length in clocks
- v_lines, out, 10, last measured lines per frame

Function
REQ-003 Each sync input SHALL pass through one sample register. A rising edge is detected in cycle N when the input is 1 in cycle N and the sample register is 0.
REQ-004 An hsync edge in cycle N SHALL make hpos equal H_SYNC_START+1 in cycle N+1.
REQ-005 With no hsync edge, hpos SHALL increment each cycle and wrap from H_TOTAL-1 to 0.
REQ-006 On an hpos wrap, vpos SHALL increment and wrap from V_TOTAL-1 to 0.
REQ-007 A vsync edge in cycle N SHALL make vpos equal V_SYNC_START in cycle N+1. The vsync load takes priority over the wrap increment.
REQ-008 An 11-bit line counter SHALL count clocks between hsync edges and saturate at 2047. At each hsync edge its value+1 is the line length; the line is good iff that length equals H_TOTAL.
REQ-009 A 10-bit counter SHALL count hsync edges between vsync edges and saturate at 1023. A frame is good iff that count equals V_TOTAL and every line in it was good.
REQ-010 When hsync and vsync edges coincide, the line check SHALL be evaluated first, and that line SHALL be included in the frame being closed.
REQ-011 The lock FSM SHALL have states SEARCH, VERIFY and LOCKED.
- SEARCH to VERIFY on the first vsync edge; good-frame count cleared to 0.
- VERIFY: a good frame increments the count; a bad frame clears it.
- VERIFY to LOCKED when the count reaches LOCK_FRAMES.
- LOCKED to SEARCH on a bad line, a bad frame, or a watchdog timeout; err pulses for exactly one cycle on this transition.
REQ-012 The watchdog SHALL trigger when no hsync edge has occurred for 2*H_TOTAL consecutive cycles. From VERIFY it returns to SEARCH without an err pulse.
REQ-013 locked SHALL be registered and equal 1 only in LOCKED.
REQ-014 display_on SHALL be combinational: locked and (hpos < H_DISPLAY) and (vpos < V_DISPLAY).
REQ-015 frame_start SHALL be registered and high only in cycles where locked=1, hpos=0 and vpos=0.

Reset
REQ-016 rst_n=0 at a clock edge SHALL clear all state, with priority over every other event including mid-frame.
REQ-017 The cleared state SHALL be:
- hpos=0, vpos=0
- locked=0, err=0, frame_start=0
- h_period=0, v_lines=0
- sample registers and all counters 0
- FSM in SEARCH

Configuration
REQ-018 With VGA_SYNC_RX_MEASURE_EN defined, h_period and v_lines SHALL update at each hsync edge and vsync edge respectively with the measured values, in every FSM state.
REQ-019 With VGA_SYNC_RX_MEASURE_EN undefined, h_period and v_lines SHALL be constant 0 and no measurement output registers SHALL exist. Lock behaviour SHALL be identical in both builds.

Structure
REQ-020 The timing defaults and the FSM state encoding SHALL live in the shared package vga_timing_pkg, also used by the sync generator.
REQ-021 Sample and edge detection SHALL be the sub-module sync_edge_detect, instantiated once per sync input.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Drive 640x480 sync (800 clocks per line, 525 lines) from reset -> locked rises during the third vsync edge's following cycle; frame_start pulses once per 420000 cycles.
- Locked stream; a single hsync arrives at 799 clocks -> err pulses once; locked=0 the next cycle; relock after 2 good frames.
- Locked; hsync held low for 1600 cycles -> watchdog fires; err=1 for 1 cycle; state SEARCH.
- Frame with 524 lines in VERIFY -> good-frame count resets; locked stays 0.
- Coincident hsync and vsync edges -> next cycle hpos=657, vpos=490.
- rst_n=0 for one cycle mid-frame while locked -> all outputs 0 next cycle; with the macro defined, h_period=800 and v_lines=525 after relock.
